// File: rtl/motoro3_pkg.sv
// Shared constants for the motoro3 phase PWM generator / capture pair.
// Counter widths, the generator's maximum period, step count and FSM encoding.
package motoro3_pkg;

  localparam int MOTORO3_CNT_W      = 16;
  localparam int MOTORO3_PERIOD_MAX = 4095;
  localparam int MOTORO3_STEPS      = 12;
  localparam int MOTORO3_STEP_W     = 4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_LOW       = 2'd3;

endpackage

// File: rtl/motoro3_pwm_deglitch.sv
// Two-flop synchronizer plus MIN_PULSE deglitch filter for the PWM readback line.
// rise/fall are asserted in the first clk that pwm_f shows its new level.
module motoro3_pwm_deglitch #(
  parameter int MIN_PULSE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic pwm,
  output logic pwm_f,
  output logic rise,
  output logic fall
);

  localparam int CW = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
  localparam logic [CW-1:0] LAST = CW'(MIN_PULSE - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sync  <= '0;
      cnt   <= '0;
      pwm_f <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pwm};
      rise <= 1'b0;
      fall <= 1'b0;
      // cnt counts consecutive samples that disagree with pwm_f
      if (sync[1] != pwm_f) begin
        if (cnt == LAST) begin
          pwm_f <= sync[1];
          rise  <= sync[1];
          fall  <= ~sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/motoro3_pwm_capture.sv
// Measures high time and rise-to-rise period of a phase PWM line, with timeout
// reporting for stuck lines and a per-commutation-step high-time accumulator.
module motoro3_pwm_capture
  import motoro3_pkg::*;
#(
  parameter int CNT_W      = MOTORO3_CNT_W,
  parameter int PERIOD_MAX = MOTORO3_PERIOD_MAX,
  parameter int MIN_PULSE  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      pwmIn,
  input  logic                      stepLast,
  input  logic [MOTORO3_STEP_W-1:0] sgStep,
  output logic                      measValid,
  output logic [CNT_W-1:0]          measHigh,
  output logic [CNT_W-1:0]          measPeriod,
  output logic                      dutyZero,
  output logic                      dutyFull,
  output logic                      stepValid,
  output logic [CNT_W-1:0]          stepAccHigh,
  output logic [MOTORO3_STEP_W-1:0] stepIdx
);

  logic             pwm_f, rise, fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] per_cnt, hi_cnt, step_acc;
  logic [CNT_W-1:0] per_nxt, hi_nxt, step_nxt;
  logic             timeout;

  motoro3_pwm_deglitch #(.MIN_PULSE(MIN_PULSE)) u_deglitch (
    .clk   (clk),
    .rst   (rst),
    .clr   (~enable),
    .pwm   (pwmIn),
    .pwm_f (pwm_f),
    .rise  (rise),
    .fall  (fall)
  );

  // saturating next values; none of the counters may wrap
  assign per_nxt  = (&per_cnt) ? per_cnt : per_cnt + 1'b1;
  assign hi_nxt   = (pwm_f && !(&hi_cnt)) ? hi_cnt + 1'b1 : hi_cnt;
  assign step_nxt = (pwm_f && !(&step_acc)) ? step_acc + 1'b1 : step_acc;
  assign timeout  = per_cnt >= CNT_W'(PERIOD_MAX - 1);

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state       <= ST_IDLE;
      per_cnt     <= '0;
      hi_cnt      <= '0;
      step_acc    <= '0;
      measValid   <= 1'b0;
      measHigh    <= '0;
      measPeriod  <= '0;
      dutyZero    <= 1'b0;
      dutyFull    <= 1'b0;
      stepValid   <= 1'b0;
      stepAccHigh <= '0;
      stepIdx     <= '0;
    end else begin
      measValid <= 1'b0;
      stepValid <= 1'b0;

      // step accumulation runs independently of the period FSM
      if (stepLast) begin
        stepAccHigh <= step_nxt;
        stepIdx     <= sgStep;
        stepValid   <= 1'b1;
        step_acc    <= '0;
      end else begin
        step_acc <= step_nxt;
      end

      case (state)
        ST_IDLE: state <= ST_WAIT_RISE;
        default: begin
          if (rise) begin
            if (state != ST_WAIT_RISE) begin
              measHigh   <= hi_cnt;
              measPeriod <= per_nxt;
              measValid  <= 1'b1;
              dutyZero   <= 1'b0;
              dutyFull   <= 1'b0;
            end
            state   <= ST_HIGH;
            per_cnt <= '0;
            hi_cnt  <= CNT_W'(1);
          end else if (timeout) begin
            // the timeout clk opens the next window, so a stuck line repeats every PERIOD_MAX
            measHigh   <= hi_cnt;
            measPeriod <= CNT_W'(PERIOD_MAX);
            measValid  <= 1'b1;
            dutyFull   <= pwm_f;
            dutyZero   <= ~pwm_f;
            state      <= ST_WAIT_RISE;
            per_cnt    <= '0;
            hi_cnt     <= CNT_W'(pwm_f);
          end else begin
            per_cnt <= per_nxt;
            hi_cnt  <= hi_nxt;
            if (state == ST_HIGH && fall) state <= ST_LOW;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// Bench for motoro3_pwm_capture: directed and random PWM waveforms compared
// against a rise-to-rise reference model on the undelayed input timeline.
module tb_motoro3_pwm_capture;

  localparam int PMAX = 4095;

  logic        clk = 1'b0;
  logic        rst, enable, pwmIn, stepLast;
  logic [3:0]  sgStep;
  logic        measValid, dutyZero, dutyFull, stepValid;
  logic [15:0] measHigh, measPeriod, stepAccHigh;
  logic [3:0]  stepIdx;

  motoro3_pwm_capture #(.CNT_W(16), .PERIOD_MAX(PMAX), .MIN_PULSE(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pwmIn       (pwmIn),
    .stepLast    (stepLast),
    .sgStep      (sgStep),
    .measValid   (measValid),
    .measHigh    (measHigh),
    .measPeriod  (measPeriod),
    .dutyZero    (dutyZero),
    .dutyFull    (dutyFull),
    .stepValid   (stepValid),
    .stepAccHigh (stepAccHigh),
    .stepIdx     (stepIdx)
  );

  always #50 clk = ~clk;

  int nvec = 0, nerr = 0, cyc = 0;
  int last_m_cyc = 0, prev_m_cyc = 0, last_s_cyc = -1;
  logic [63:0] got_m[$], exp_m[$], got_s[$], exp_s[$];

  // reference model state: waveform seen as clean rise-to-rise windows
  bit active, waiting, pv;
  int since, hi, acc;
  bit hist[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    active = 0; waiting = 0; pv = 0; since = 0; hi = 0; acc = 0;
    hist.delete();
  endtask

  // v: clean level, g: glitch inverts the driven pin, sl: stepLast this clk
  task automatic tick(input bit v, input bit g = 1'b0, input bit sl = 1'b0);
    bit dly;
    pwmIn    = v ^ g;
    stepLast = sl;
    if (rst || !enable) begin
      model_clear();
    end else begin
      if (v && !pv) begin
        if (active && !waiting) exp_m.push_back({30'd0, 16'(hi), 16'(since), 1'b0, 1'b0});
        active = 1; waiting = 0; since = 1; hi = 1;
      end else if (active) begin
        if (since == PMAX) begin
          exp_m.push_back({30'd0, 16'(hi), 16'(PMAX), !v, v});
          waiting = 1; since = 1; hi = int'(v);
        end else begin
          since++; hi += int'(v);
        end
      end
      pv = v;
      // filtered line lags the pin by five clks
      dly = (hist.size() >= 5) ? hist[hist.size()-5] : 1'b0;
      if (sl) begin
        exp_s.push_back({44'd0, 16'(acc + int'(dly)), sgStep});
        acc = 0;
      end else begin
        acc += int'(dly);
      end
      hist.push_back(v);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    if (measValid) begin
      got_m.push_back({30'd0, measHigh, measPeriod, dutyZero, dutyFull});
      prev_m_cyc = last_m_cyc;
      last_m_cyc = cyc;
    end
    if (stepValid) begin
      got_s.push_back({44'd0, stepAccHigh, stepIdx});
      last_s_cyc = cyc;
    end
  endtask

  task automatic period(input int h, input int p, input int sl_at = -1, input int gl_at = -1);
    for (int i = 0; i < p; i++)
      tick(i < h, gl_at >= 0 && (i == gl_at || i == gl_at + 1), i == sl_at);
  endtask

  task automatic idle(input int n, input bit v);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  task automatic compare(input string tag);
    check({tag, "_meas_count"}, 64'(got_m.size()), 64'(exp_m.size()));
    while (got_m.size() > 0 && exp_m.size() > 0) check({tag, "_meas"}, got_m.pop_front(), exp_m.pop_front());
    check({tag, "_step_count"}, 64'(got_s.size()), 64'(exp_s.size()));
    while (got_s.size() > 0 && exp_s.size() > 0) check({tag, "_step"}, got_s.pop_front(), exp_s.pop_front());
    got_m.delete(); exp_m.delete(); got_s.delete(); exp_s.delete();
  endtask

  function automatic logic [63:0] all_outs();
    return {8'd0, measValid, measHigh, measPeriod, dutyZero, dutyFull, stepValid, stepAccHigh, stepIdx};
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0; pwmIn = 1'b0; stepLast = 1'b0; sgStep = 4'd0;
    model_clear();
    idle(3, 0);
    check("reset_outputs", all_outs(), 64'd0);

    // nominal 100/30 waveform: first rise silent, then one report per period
    rst = 1'b0; enable = 1'b1;
    idle(20, 0);
    repeat (4) period(30, 100);
    idle(10, 0);
    compare("nominal");
    check("nominal_high", 64'(measHigh), 64'd30);
    check("nominal_period", 64'(measPeriod), 64'd100);

    // 2-clk low spike inside the high phase is filtered out
    repeat (3) period(30, 100, -1, 10);
    idle(10, 0);
    compare("glitch");
    check("glitch_high", 64'(measHigh), 64'd30);

    // random periods and step boundaries
    for (int k = 0; k < 25; k++) begin
      int p, h, s;
      p = int'($urandom_range(300, 8));
      h = int'($urandom_range(p - 3, 3));
      s = ($urandom_range(3, 0) == 0) ? int'($urandom_range(p - 1, 0)) : -1;
      sgStep = 4'($urandom_range(11, 0));
      period(h, p, s);
    end
    idle(10, 0);
    compare("random");

    // step accumulation over five 100/30 periods
    sgStep = 4'd0;
    for (int i = 0; i < 20; i++) tick(0, 0, i == 10);
    compare("step_clear");
    repeat (5) period(30, 100);
    sgStep = 4'd7;
    for (int i = 0; i < 20; i++) tick(0, 0, i == 10);
    compare("step5");
    check("step5_acc", 64'(stepAccHigh), 64'd150);
    check("step5_idx", 64'(stepIdx), 64'd7);
    sgStep = 4'd8;
    period(30, 100);
    period(30, 100, 10);
    idle(10, 0);
    compare("step_high_clk");

    // stepLast on the same clk as a reported rise
    sgStep = 4'd3;
    period(30, 100);
    period(30, 100, 5);
    idle(10, 0);
    compare("simul");
    check("simul_same_clk", 64'(last_s_cyc), 64'(last_m_cyc));

    // stuck high, then recovery
    period(30, 100);
    idle(2 * PMAX + 10, 1);
    compare("stuck_hi");
    check("stuck_hi_full", 64'(dutyFull), 64'd1);
    check("stuck_hi_period", 64'(measPeriod), 64'(PMAX));
    check("stuck_hi_spacing", 64'(last_m_cyc - prev_m_cyc), 64'(PMAX));
    idle(70, 0);
    repeat (3) period(30, 100);
    idle(10, 0);
    compare("recover_hi");
    check("recover_hi_high", 64'(measHigh), 64'd30);
    check("recover_hi_full", 64'(dutyFull), 64'd0);

    // stuck low, then recovery
    idle(2 * PMAX + 10, 0);
    compare("stuck_lo");
    check("stuck_lo_zero", 64'(dutyZero), 64'd1);
    check("stuck_lo_high", 64'(measHigh), 64'd0);
    check("stuck_lo_spacing", 64'(last_m_cyc - prev_m_cyc), 64'(PMAX));
    repeat (3) period(30, 100);
    idle(10, 0);
    compare("recover_lo");
    check("recover_lo_zero", 64'(dutyZero), 64'd0);
    check("recover_lo_period", 64'(measPeriod), 64'd100);

    // enable dropped mid-HIGH
    repeat (2) period(30, 100);
    idle(15, 1);
    compare("pre_disable");
    enable = 1'b0;
    tick(1);
    check("disable_outputs", all_outs(), 64'd0);
    idle(5, 0);
    enable = 1'b1;
    idle(40, 0);
    repeat (3) period(30, 100);
    idle(10, 0);
    compare("reenable");

    // synchronous reset mid-HIGH
    repeat (2) period(30, 100);
    idle(15, 1);
    compare("pre_reset");
    rst = 1'b1;
    tick(1);
    check("rst_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    idle(40, 0);
    repeat (3) period(30, 100);
    idle(10, 0);
    compare("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
